// File: rtl/nvdla_dbb_read_adapter_pkg.sv
// rtl/nvdla_dbb_read_adapter_pkg.sv - shared FSM, streamer-control types and constants for the DBB read adapter
package nvdla_package;

  localparam int NVDLA_DBB_MEMIF_DEFAULT = 64;
  localparam int NVDLA_DBB_WPB           = NVDLA_DBB_MEMIF_DEFAULT / 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PACK,
    OUT,
    DRAIN
  } state_dbb_rd_fsm_t;

  typedef struct packed {
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] words;
  } ctrl_dbb_rd_src_t;

  // 32-bit words needed to fill (len+1) beats
  function automatic logic [15:0] dbb_rd_words(input logic [3:0] len, input int wpb);
    return 16'(({28'd0, len} + 32'd1) * 32'(wpb));
  endfunction

endpackage

// File: rtl/nvdla_dbb_beat_packer.sv
// rtl/nvdla_dbb_beat_packer.sv - packs 32-bit stream words little-endian into one DBB beat
module nvdla_dbb_beat_packer
  import nvdla_package::*;
#(
  parameter int WPB = NVDLA_DBB_WPB
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  input  logic              in_en_i,
  input  logic [31:0]       in_data_i,
  output logic [WPB*32-1:0] beat_o,
  output logic              beat_done_o
);

  localparam int CW = (WPB > 1) ? $clog2(WPB) : 1;

  logic [CW-1:0]     r_word_cnt;
  logic [WPB*32-1:0] r_beat;
  logic              w_hs;
  logic              w_slot_last;

  assign w_hs        = in_valid_i & in_en_i;
  assign w_slot_last = (r_word_cnt == CW'(WPB - 1));
  assign beat_done_o = w_hs & w_slot_last;
  assign beat_o      = r_beat;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_word_cnt <= '0;
      r_beat     <= '0;
    end else if (w_hs) begin
      r_beat[32*r_word_cnt +: 32] <= in_data_i;
      r_word_cnt                  <= w_slot_last ? '0 : r_word_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nvdla_dbb_read_adapter.sv
// rtl/nvdla_dbb_read_adapter.sv - DBB read request to HWPE streamer fetch and beat return
// NVDLA_DBB_RD_SKID_EN adds a 2-entry output FIFO so packing overlaps beat return.
module nvdla_dbb_read_adapter
  import nvdla_package::*;
#(
  parameter int NVDLA_PRIMARY_MEMIF_WIDTH = NVDLA_DBB_MEMIF_DEFAULT,
  parameter int STREAM_WIDTH              = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clear_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [31:0]                          req_addr_i,
  input  logic [3:0]                           req_len_i,
  input  logic [7:0]                           req_id_i,
  output logic                                 src_start_o,
  output logic [31:0]                          src_base_addr_o,
  output logic [15:0]                          src_words_o,
  input  logic                                 src_done_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [STREAM_WIDTH-1:0]              in_data_i,
  output logic                                 rdat_valid_o,
  input  logic                                 rdat_ready_i,
  output logic [NVDLA_PRIMARY_MEMIF_WIDTH-1:0] rdat_data_o,
  output logic                                 rdat_last_o,
  output logic [7:0]                           rdat_id_o,
  output logic                                 busy_o
);

  localparam int DW = NVDLA_PRIMARY_MEMIF_WIDTH;
  localparam int WPB = DW / 32;
  localparam int AB = $clog2(WPB * 4);
  localparam logic [31:0] ADDR_MASK = ~32'((1 << AB) - 1);

  state_dbb_rd_fsm_t r_state;
  ctrl_dbb_rd_src_t  r_src;
  logic [3:0]        r_len;
  logic [3:0]        r_beat_cnt;
  logic [7:0]        r_id;
  logic              r_done_seen;
  logic [DW-1:0]     w_beat;
  logic              w_beat_done;
  logic              w_in_ready;

  nvdla_dbb_beat_packer #(.WPB(WPB)) u_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .in_valid_i (in_valid_i),
    .in_en_i    (w_in_ready),
    .in_data_i  (in_data_i),
    .beat_o     (w_beat),
    .beat_done_o(w_beat_done)
  );

`ifdef NVDLA_DBB_RD_SKID_EN
  logic [DW:0] r_fifo [2];
  logic [1:0]  r_fcnt;
  logic        r_rptr;
  logic        r_wptr;
  logic        r_pend;
  logic        r_pend_last;
  logic        w_push;
  logic        w_pop;

  // a completed beat sits in the packer one cycle before it moves into the FIFO
  assign w_in_ready   = (r_state == PACK) && !(r_pend && (r_fcnt == 2'd2));
  assign rdat_valid_o = (r_fcnt != 2'd0);
  assign rdat_data_o  = r_fifo[r_rptr][DW-1:0];
  assign rdat_last_o  = rdat_valid_o && r_fifo[r_rptr][DW];
  assign w_pop        = rdat_valid_o && rdat_ready_i;
  assign w_push       = r_pend && (r_fcnt != 2'd2);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
      r_fcnt      <= '0;
      r_rptr      <= 1'b0;
      r_wptr      <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {r_pend_last, w_beat};
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      if (w_beat_done) begin
        r_pend      <= 1'b1;
        r_pend_last <= (r_beat_cnt == r_len);
      end else if (w_push) begin
        r_pend <= 1'b0;
      end
      r_fcnt <= r_fcnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
`else
  assign w_in_ready   = (r_state == PACK);
  assign rdat_valid_o = (r_state == OUT);
  assign rdat_data_o  = w_beat;
  assign rdat_last_o  = (r_state == OUT) && (r_beat_cnt == r_len);
`endif

  assign in_ready_o      = w_in_ready;
  assign req_ready_o     = (r_state == IDLE);
  assign busy_o          = (r_state != IDLE);
  assign rdat_id_o       = r_id;
  assign src_start_o     = r_src.start;
  assign src_base_addr_o = r_src.base_addr;
  assign src_words_o     = r_src.words;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_len       <= '0;
      r_id        <= '0;
      r_beat_cnt  <= '0;
      r_done_seen <= 1'b0;
    end else begin
      r_src.start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_src       <= '{start: 1'b1, base_addr: req_addr_i & ADDR_MASK,
                             words: dbb_rd_words(req_len_i, WPB)};
            r_len       <= req_len_i;
            r_id        <= req_id_i;
            r_beat_cnt  <= '0;
            r_done_seen <= 1'b0;
            r_state     <= START;
          end
        end
        START: r_state <= PACK;
        PACK: begin
          if (src_done_i) r_done_seen <= 1'b1;
          if (w_beat_done) begin
`ifdef NVDLA_DBB_RD_SKID_EN
            if (r_beat_cnt == r_len) r_state <= OUT;
            else r_beat_cnt <= r_beat_cnt + 4'd1;
`else
            r_state <= OUT;
`endif
          end
        end
        OUT: begin
          if (src_done_i) r_done_seen <= 1'b1;
`ifdef NVDLA_DBB_RD_SKID_EN
          if (w_pop && rdat_last_o) r_state <= DRAIN;
`else
          if (rdat_ready_i) begin
            if (rdat_last_o) begin
              r_state <= DRAIN;
            end else begin
              r_beat_cnt <= r_beat_cnt + 4'd1;
              r_state    <= PACK;
            end
          end
`endif
        end
        DRAIN: begin
          if (src_done_i || r_done_seen) begin
            r_done_seen <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvdla_dbb_read_adapter.sv
// tb/tb_nvdla_dbb_read_adapter.sv - self-checking bench: vector table, random transactions vs word-queue model
module tb_nvdla_dbb_read_adapter;

  localparam int MW  = 64;
  localparam int WPB = MW / 32;

  logic          clk = 1'b0;
  logic          rst_i, clear_i;
  logic          req_valid_i, req_ready_o;
  logic [31:0]   req_addr_i;
  logic [3:0]    req_len_i;
  logic [7:0]    req_id_i;
  logic          src_start_o;
  logic [31:0]   src_base_addr_o;
  logic [15:0]   src_words_o;
  logic          src_done_i;
  logic          in_valid_i, in_ready_o;
  logic [31:0]   in_data_i;
  logic          rdat_valid_o, rdat_ready_i;
  logic [MW-1:0] rdat_data_o;
  logic          rdat_last_o;
  logic [7:0]    rdat_id_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  bit          hold_next = 1'b0;
  logic [31:0] next_addr;
  logic [3:0]  next_len;
  logic [7:0]  next_id;

  always #5 clk = ~clk;

  nvdla_dbb_read_adapter #(.NVDLA_PRIMARY_MEMIF_WIDTH(MW), .STREAM_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_len_i(req_len_i), .req_id_i(req_id_i),
    .src_start_o(src_start_o), .src_base_addr_o(src_base_addr_o), .src_words_o(src_words_o),
    .src_done_i(src_done_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .rdat_valid_o(rdat_valid_o), .rdat_ready_i(rdat_ready_i), .rdat_data_o(rdat_data_o),
    .rdat_last_o(rdat_last_o), .rdat_id_o(rdat_id_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [7:0]  id;
    int          rdy_pct;
    int          val_pct;
    bit          done_early;
    int          data_mode;
    logic [31:0] exp_base;
    logic [15:0] exp_words;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // every drive and sample happens 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
    int n = 0;
    req_addr_i  = addr;
    req_len_i   = len;
    req_id_i    = id;
    req_valid_i = 1'b1;
    while (!req_ready_o && n < 3000) begin tick(); n++; end
    if (n >= 3000) chk("req_accept_timeout", 0, 1);
    tick();
    if (hold_next) begin
      req_addr_i = next_addr;
      req_len_i  = next_len;
      req_id_i   = next_id;
    end else begin
      req_valid_i = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] d);
    int n = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    while (!in_ready_o && n < 50) begin tick(); n++; end
    if (n >= 50) chk("word_accept_timeout", 0, 1);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic accept_beat(input logic [MW-1:0] exp_data, input logic exp_last, input logic [7:0] exp_id);
    int n = 0;
    rdat_ready_i = 1'b1;
    while (!rdat_valid_o && n < 50) begin tick(); n++; end
    chk("hand_beat_valid", rdat_valid_o, 1);
    chk("hand_beat_data", rdat_data_o, exp_data);
    chk("hand_beat_last", rdat_last_o, exp_last);
    chk("hand_beat_id", rdat_id_o, exp_id);
    tick();
    rdat_ready_i = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_req_ready"}, req_ready_o, 1);
    chk({tag, "_rdat_valid"}, rdat_valid_o, 0);
    chk({tag, "_in_ready"}, in_ready_o, 0);
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id,
                         input logic [31:0] exp_base, input logic [15:0] exp_words,
                         input int rdy_pct, input int val_pct, input bit done_early, input int data_mode);
    logic [31:0]   words[$];
    logic [MW-1:0] exp_beats[$];
    logic [MW-1:0] b, prev_data;
    int nb = int'(len) + 1;
    int nw = nb * WPB;
    int wi = 0, bi = 0, n = 0, lat = 1;
    bit prev_hold = 0, first_seen = 0, done_pulsed = 0;

    for (int i = 0; i < nw; i++) begin
      if (data_mode == 1) words.push_back(32'(i));
      else if (data_mode == 2) words.push_back(32'h1111_1111 * 32'(i + 1));
      else words.push_back($urandom);
    end
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < WPB; j++) b[32*j +: 32] = words[k*WPB + j];
      exp_beats.push_back(b);
    end

    do_req(addr, len, id);
    chk("src_start", src_start_o, 1);
    chk("src_base_addr", src_base_addr_o, exp_base);
    chk("src_words", src_words_o, exp_words);

    while (bi < nb && n < 3000) begin
      if (prev_hold) begin
        chk("valid_held", rdat_valid_o, 1);
        chk("data_held", rdat_data_o, prev_data);
      end
      if (n >= 1) chk("start_one_cycle", src_start_o, 0);
      chk("req_ready_busy", req_ready_o, 0);
      if (!first_seen && rdat_valid_o) begin
        first_seen = 1;
        chk("latency_min", lat >= WPB + 2, 1);
      end
      in_valid_i = (wi < nw) && ($urandom_range(99) < val_pct);
      in_data_i  = in_valid_i ? words[wi] : $urandom;
      if (done_early && rdat_valid_o && bi == nb - 1 && !done_pulsed) begin
        rdat_ready_i = 1'b0;
        src_done_i   = 1'b1;
        done_pulsed  = 1;
      end else begin
        src_done_i   = 1'b0;
        rdat_ready_i = (done_early && done_pulsed) ? 1'b1 : ($urandom_range(99) < rdy_pct);
      end
      if (in_valid_i && in_ready_o) wi++;
      if (rdat_valid_o && rdat_ready_i) begin
        chk("beat_data", rdat_data_o, exp_beats[bi]);
        chk("beat_last", rdat_last_o, bi == nb - 1);
        chk("beat_id", rdat_id_o, id);
        bi++;
        prev_hold = 0;
      end else begin
        prev_hold = rdat_valid_o;
        prev_data = rdat_data_o;
      end
      tick();
      n++;
      lat++;
    end
    if (bi < nb) chk("txn_timeout", bi, nb);
    in_valid_i   = 1'b0;
    rdat_ready_i = 1'b0;
    src_done_i   = 1'b0;

    if (done_early) begin
      chk("drain_one_cycle_busy", busy_o, 1);
      tick();
      chk("drain_exit_busy", busy_o, 0);
      chk("drain_exit_req_ready", req_ready_o, 1);
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk("drain_wait_busy", busy_o, 1);
        chk("drain_wait_req_ready", req_ready_o, 0);
        tick();
      end
      src_done_i = 1'b1;
      tick();
      src_done_i = 1'b0;
      chk("drain_done_busy", busy_o, 0);
      chk("drain_done_req_ready", req_ready_o, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h1000_0004, 4'd0,  8'h5A, 100, 100, 1'b0, 2, 32'h1000_0000, 16'd2};
    vecs[1] = '{32'h2000_0000, 4'd15, 8'h33, 100, 100, 1'b0, 1, 32'h2000_0000, 16'd32};
    vecs[2] = '{32'h0000_0ABF, 4'd3,  8'hC3, 50,  60,  1'b1, 0, 32'h0000_0AB8, 16'd8};
    vecs[3] = '{32'hFFFF_FFFF, 4'd7,  8'hFF, 30,  100, 1'b0, 0, 32'hFFFF_FFF8, 16'd16};

    rst_i = 1'b1; clear_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_len_i = '0;
    req_id_i = '0; src_done_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; rdat_ready_i = 1'b0;
    tick(); tick(); tick();
    rst_i = 1'b0;
    tick();

    chk_idle("reset");
    chk("reset_src_start", src_start_o, 0);
    chk("reset_src_base", src_base_addr_o, 0);
    chk("reset_src_words", src_words_o, 0);
    chk("reset_rdat_data", rdat_data_o, 0);
    chk("reset_rdat_last", rdat_last_o, 0);
    chk("reset_rdat_id", rdat_id_o, 0);

    for (int v = 0; v < 4; v++)
      run_txn(vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].exp_base, vecs[v].exp_words,
              vecs[v].rdy_pct, vecs[v].val_pct, vecs[v].done_early, vecs[v].data_mode);

    // beat 0 stalled for 5 cycles with no further words offered
    do_req(32'h3000_0010, 4'd1, 8'h77);
    send_word(32'hA0A0_0000);
    send_word(32'hA1A1_1111);
    begin
      int n = 0;
      while (!rdat_valid_o && n < 50) begin tick(); n++; end
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", rdat_valid_o, 1);
      chk("stall_data", rdat_data_o, 64'hA1A1_1111_A0A0_0000);
      chk("stall_last", rdat_last_o, 0);
      chk("stall_id", rdat_id_o, 8'h77);
`ifdef NVDLA_DBB_RD_SKID_EN
      chk("stall_in_ready", in_ready_o, 1);
`else
      chk("stall_in_ready", in_ready_o, 0);
`endif
      tick();
    end
    accept_beat(64'hA1A1_1111_A0A0_0000, 1'b0, 8'h77);
    send_word(32'hB0B0_2222);
    send_word(32'hB1B1_3333);
    accept_beat(64'hB1B1_3333_B0B0_2222, 1'b1, 8'h77);
    src_done_i = 1'b1;
    tick();
    src_done_i = 1'b0;
    chk_idle("stall_end");

    // abort after 3 of 8 words
    do_req(32'h4000_0000, 4'd3, 8'h99);
    send_word(32'hC0C0_0000);
    send_word(32'hC1C1_0001);
    accept_beat(64'hC1C1_0001_C0C0_0000, 1'b0, 8'h99);
    send_word(32'hC2C2_0002);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk_idle("clear");
    chk("clear_rdat_id", rdat_id_o, 0);
    chk("clear_rdat_data", rdat_data_o, 0);
    chk("clear_src_words", src_words_o, 0);
    chk("clear_src_base", src_base_addr_o, 0);
    run_txn(32'h4000_0100, 4'd2, 8'h01, 32'h4000_0100, 16'd6, 100, 100, 1'b0, 0);

    // second request held valid for the whole first transaction
    hold_next = 1'b1;
    next_addr = 32'h6000_000C;
    next_len  = 4'd1;
    next_id   = 8'h20;
    run_txn(32'h5000_0000, 4'd2, 8'h10, 32'h5000_0000, 16'd6, 70, 80, 1'b0, 0);
    hold_next = 1'b0;
    run_txn(32'h6000_000C, 4'd1, 8'h20, 32'h6000_0008, 16'd4, 100, 100, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      logic [31:0] a;
      logic [3:0]  l;
      logic [7:0]  id;
      int          li;
      a  = $urandom;
      l  = 4'($urandom_range(15));
      id = 8'($urandom);
      li = int'(l);
      run_txn(a, l, id, a & ~32'(MW / 8 - 1), 16'((li + 1) * WPB),
              $urandom_range(100, 20), $urandom_range(100, 20), t[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
